// File: rtl/cms_pkg.sv
// Shared types, register map and default sizes for the trace packer.
package cms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_ACTIVE
    } trig_state_e;

    localparam int ADDR_CTRL       = 'h00;
    localparam int ADDR_TRIG_START = 'h01;
    localparam int ADDR_TRIG_STOP  = 'h02;
    localparam int ADDR_DROP_CLR   = 'h03;

    localparam int DEF_XLEN            = 64;
    localparam int DEF_NO_OF_EVENTS    = 37;
    localparam int DEF_COUNTER_WIDTH   = 8;
    localparam int DEF_CTRL_ADDR_WIDTH = 8;
    localparam int DEF_CTRL_DATA_WIDTH = 64;
    localparam int DEF_AXI_DATA_WIDTH  = 512;
    localparam int DEF_FIFO_DEPTH      = 8;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cms_trace_packer_if.sv
// AXI-Stream style output bus of the trace packer.
interface cms_trace_packer_if #(
    parameter int DATA_WIDTH = 512
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/cms_sync_fifo.sv
// Single-clock FIFO; push is refused when full, pop when empty.
module cms_sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push/pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; stale entries are unreachable because empty masks the read data.
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cms_trace_packer.sv
// Retire-trace packer: triggered capture of pc/instr/event counters into an output stream.
module cms_trace_packer
    import cms_pkg::*;
#(
    parameter int XLEN                     = DEF_XLEN,
    parameter int NO_OF_PERFORMANCE_EVENTS = DEF_NO_OF_EVENTS,
    parameter int COUNTER_WIDTH            = DEF_COUNTER_WIDTH,
    parameter int CTRL_ADDR_WIDTH          = DEF_CTRL_ADDR_WIDTH,
    parameter int CTRL_DATA_WIDTH          = DEF_CTRL_DATA_WIDTH,
    parameter int AXI_DATA_WIDTH           = DEF_AXI_DATA_WIDTH,
    parameter int FIFO_DEPTH               = DEF_FIFO_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [31:0]                         instr,
    input  logic [XLEN-1:0]                     pc,
    input  logic                                pc_valid,
    input  logic [NO_OF_PERFORMANCE_EVENTS-1:0] performance_events,
    input  logic [CTRL_ADDR_WIDTH-1:0]          ctrl_addr,
    input  logic [CTRL_DATA_WIDTH-1:0]          ctrl_wdata,
    input  logic                                ctrl_write_enable,
    input  logic [31:0]                         tlast_interval,
    cms_trace_packer_if.master                  M_AXIS,
    output logic [31:0]                         drop_count
);
    localparam int NE      = NO_OF_PERFORMANCE_EVENTS;
    localparam int CW      = COUNTER_WIDTH;
    localparam int CNT_LSB = XLEN + 32;
    localparam int ITEM_W  = CNT_LSB + NE * CW;

    if (ITEM_W > AXI_DATA_WIDTH) begin : g_width_check
        $error("cms_trace_packer: item width exceeds AXI_DATA_WIDTH");
    end

    logic                      we_prev_q, we_prev_d;
    logic                      mon_en_q, mon_en_d, trig_en_q, trig_en_d;
    logic [XLEN-1:0]           trig_start_q, trig_start_d, trig_stop_q, trig_stop_d;
    trig_state_e               state_q, state_d;
    logic [CW-1:0]             cnt_q [NE];
    logic [CW-1:0]             cnt_d [NE];
    logic [CW-1:0]             cnt_now [NE];
    logic [31:0]               drop_q, drop_d, beat_q, beat_d;
    logic                      ctrl_wr, drop_clr, capture, push, drop, pop, tlast_hit;
    logic                      fifo_full, fifo_empty, axis_valid;
    logic [AXI_DATA_WIDTH-1:0] item, fifo_rdata;

    // Rising-edge control writes into the register map.
    always_comb begin
        ctrl_wr      = ctrl_write_enable && !we_prev_q;
        we_prev_d    = ctrl_write_enable;
        mon_en_d     = mon_en_q;
        trig_en_d    = trig_en_q;
        trig_start_d = trig_start_q;
        trig_stop_d  = trig_stop_q;
        drop_clr     = ctrl_wr && (ctrl_addr == CTRL_ADDR_WIDTH'(ADDR_DROP_CLR));
        if (ctrl_wr && ctrl_addr == CTRL_ADDR_WIDTH'(ADDR_CTRL)) begin
            mon_en_d  = ctrl_wdata[0];
            trig_en_d = ctrl_wdata[1];
        end
        if (ctrl_wr && ctrl_addr == CTRL_ADDR_WIDTH'(ADDR_TRIG_START)) trig_start_d = XLEN'(ctrl_wdata);
        if (ctrl_wr && ctrl_addr == CTRL_ADDR_WIDTH'(ADDR_TRIG_STOP))  trig_stop_d  = XLEN'(ctrl_wdata);
    end

    // Trigger FSM next state and capture decision.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (!mon_en_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       state_d = trig_en_q ? ST_WAIT_START : ST_ACTIVE;
                ST_WAIT_START: if (pc_valid && pc == trig_start_q) begin
                    capture = 1'b1;
                    state_d = ST_ACTIVE;
                end
                ST_ACTIVE:     if (pc_valid) begin
                    capture = 1'b1;
                    if (trig_en_q && pc == trig_stop_q) state_d = ST_WAIT_START;
                end
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    // Event counters, item assembly and drop accounting.
    always_comb begin
        push = capture && !fifo_full;
        drop = capture && fifo_full;
        item = '0;
        item[XLEN-1:0]   = pc;
        item[XLEN +: 32] = instr;
        for (int i = 0; i < NE; i++) begin
            cnt_now[i] = (performance_events[i] && cnt_q[i] != '1) ? cnt_q[i] + CW'(1) : cnt_q[i];
            cnt_d[i]   = push ? '0 : cnt_now[i];
            item[CNT_LSB + i*CW +: CW] = cnt_now[i];
        end
        drop_d = drop_q;
        if (drop)          drop_d = drop_clr ? 32'd1 : sat_inc32(drop_q);
        else if (drop_clr) drop_d = '0;
    end

    // Beat counter and packet boundary.
    always_comb begin
        pop       = axis_valid && M_AXIS.tready;
        tlast_hit = (tlast_interval != 32'd0) && (beat_q >= tlast_interval - 32'd1);
        beat_d    = beat_q;
        if (pop) beat_d = tlast_hit ? '0 : beat_q + 32'd1;
    end

    // All packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_prev_q    <= 1'b1;
            mon_en_q     <= 1'b0;
            trig_en_q    <= 1'b0;
            trig_start_q <= '0;
            trig_stop_q  <= '0;
            state_q      <= ST_IDLE;
            drop_q       <= '0;
            beat_q       <= '0;
            for (int i = 0; i < NE; i++) cnt_q[i] <= '0;
        end else begin
            we_prev_q    <= we_prev_d;
            mon_en_q     <= mon_en_d;
            trig_en_q    <= trig_en_d;
            trig_start_q <= trig_start_d;
            trig_stop_q  <= trig_stop_d;
            state_q      <= state_d;
            drop_q       <= drop_d;
            beat_q       <= beat_d;
            for (int i = 0; i < NE; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    cms_sync_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (item),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign axis_valid    = !fifo_empty;
    assign M_AXIS.tvalid = axis_valid;
    assign M_AXIS.tdata  = fifo_rdata;
    assign M_AXIS.tlast  = axis_valid && tlast_hit;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_cms_trace_packer.sv
// Self-checking bench: directed stimulus, per-cycle model comparison, literal spot checks.
module tb_cms_trace_packer;

    localparam int XL    = 64;
    localparam int NE    = 37;
    localparam int DW    = 512;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instr;
    logic [XL-1:0] pc;
    logic          pc_valid;
    logic [NE-1:0] performance_events;
    logic [7:0]    ctrl_addr;
    logic [63:0]   ctrl_wdata;
    logic          ctrl_write_enable;
    logic [31:0]   tlast_interval;
    logic          tready;
    logic [31:0]   drop_count;

    always #5 clk = ~clk;

    cms_trace_packer_if #(.DATA_WIDTH(DW)) axis ();
    assign axis.tready = tready;

    cms_trace_packer dut (
        .clk                (clk),
        .rst                (rst),
        .instr              (instr),
        .pc                 (pc),
        .pc_valid           (pc_valid),
        .performance_events (performance_events),
        .ctrl_addr          (ctrl_addr),
        .ctrl_wdata         (ctrl_wdata),
        .ctrl_write_enable  (ctrl_write_enable),
        .tlast_interval     (tlast_interval),
        .M_AXIS             (axis),
        .drop_count         (drop_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_ok = 0;
    bit          m_prev_we;
    bit          m_mon, m_trig;
    logic [63:0] m_start, m_stop;
    int          m_mode;            // 0 off, 1 armed waiting for start, 2 tracing
    int          m_cnt [NE];
    logic [DW-1:0] m_q [$];
    logic [31:0] m_dc;
    logic [31:0] m_beats;

    logic [DW-1:0] log_data [$];
    bit            log_last [$];

    function automatic bit exp_last();
        return (tlast_interval != 0) && (m_beats >= tlast_interval - 32'd1);
    endfunction

    always @(posedge clk) begin
        bit wr, clr, cap, popb, lastb;
        int nxt, occ;
        logic [DW-1:0] it;
        if (rst) begin
            m_ok = 1; m_mon = 0; m_trig = 0; m_start = '0; m_stop = '0; m_mode = 0;
            m_q.delete(); m_dc = '0; m_beats = '0;
            for (int i = 0; i < NE; i++) m_cnt[i] = 0;
        end else if (m_ok) begin
            occ  = m_q.size();
            popb = (occ > 0) && tready;
            wr   = ctrl_write_enable && !m_prev_we;
            clr  = wr && (ctrl_addr == 8'h03);
            for (int i = 0; i < NE; i++)
                if (performance_events[i] && m_cnt[i] < 255) m_cnt[i]++;
            cap = 0; nxt = m_mode;
            if (!m_mon) nxt = 0;
            else if (m_mode == 0) nxt = m_trig ? 1 : 2;
            else if (m_mode == 1) begin
                if (pc_valid && pc == m_start) begin cap = 1; nxt = 2; end
            end else if (pc_valid) begin
                cap = 1;
                if (m_trig && pc == m_stop) nxt = 1;
            end
            if (popb) begin
                lastb = exp_last();
                m_beats = lastb ? 32'd0 : m_beats + 32'd1;
                void'(m_q.pop_front());
            end
            if (cap) begin
                it = '0;
                it[63:0]  = pc;
                it[95:64] = instr;
                for (int i = 0; i < NE; i++) it[96 + 8*i +: 8] = 8'(m_cnt[i]);
                if (occ >= DEPTH) begin
                    m_dc = clr ? 32'd1 : ((m_dc == 32'hFFFF_FFFF) ? m_dc : m_dc + 32'd1);
                    clr = 0;
                end else begin
                    m_q.push_back(it);
                    for (int i = 0; i < NE; i++) m_cnt[i] = 0;
                end
            end
            if (clr) m_dc = '0;
            if (wr && ctrl_addr == 8'h00) begin m_mon = ctrl_wdata[0]; m_trig = ctrl_wdata[1]; end
            if (wr && ctrl_addr == 8'h01) m_start = ctrl_wdata;
            if (wr && ctrl_addr == 8'h02) m_stop  = ctrl_wdata;
            m_mode = nxt;
        end
        m_prev_we = rst ? 1'b1 : ctrl_write_enable;
    end

    // Handshake log for directed checks.
    always @(posedge clk) begin
        if (!rst && axis.tvalid && tready) begin
            log_data.push_back(axis.tdata);
            log_last.push_back(axis.tlast);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ok && !rst) begin
            check("tvalid", axis.tvalid, m_q.size() != 0);
            check("drop_count", drop_count, m_dc);
            if (m_q.size() != 0) begin
                check("tdata", axis.tdata, m_q[0]);
                check("tlast", axis.tlast, exp_last());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
        pc_valid = 0;
        performance_events = '0;
        ctrl_write_enable = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        ctrl_addr = a; ctrl_wdata = d; ctrl_write_enable = 1;
        tick(); tick();
    endtask

    task automatic ret(input logic [63:0] p, input logic [31:0] ins);
        pc_valid = 1; pc = p; instr = ins;
        tick();
    endtask

    logic [DW-1:0] exp_item;
    logic [DW-1:0] tmp;

    initial begin
        rst = 1; tready = 1; pc_valid = 0; pc = '0; instr = '0; performance_events = '0;
        ctrl_addr = 8'h00; ctrl_wdata = 64'h3; ctrl_write_enable = 1; tlast_interval = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid", axis.tvalid, 0);
        check("reset_tlast", axis.tlast, 0);
        check("reset_tdata", axis.tdata, 0);
        check("reset_drop_count", drop_count, 0);
        // Strobe held high through reset release must not write.
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        ctrl_write_enable = 0; ctrl_wdata = '0;
        ret(64'h500, 32'h13);
        idle(3);
        check("held_strobe_no_write", log_data.size(), 0);

        // Single capture with event 3 counted twice beforehand.
        log_data.delete(); log_last.delete();
        wr(8'h00, 64'h1); idle(2);
        performance_events = 37'h8; tick();
        performance_events = 37'h8; tick();
        ret(64'h1000, 32'h13);
        idle(3);
        check("single_beat_count", log_data.size(), 1);
        exp_item = (512'h2 << 120) | (512'h13 << 64) | 512'h1000;
        if (log_data.size() > 0) check("single_beat_item", log_data[0], exp_item);

        // Start/stop trigger window.
        log_data.delete(); log_last.delete();
        wr(8'h00, 64'h0);
        wr(8'h01, 64'h2000);
        wr(8'h02, 64'h2010);
        wr(8'h00, 64'h3); idle(2);
        for (int k = 0; k < 9; k++) ret(64'h1FF8 + 64'(4*k), 32'h13);
        idle(3);
        check("trigger_beat_count", log_data.size(), 5);
        for (int i = 0; i < log_data.size(); i++) begin
            tmp = log_data[i];
            check("trigger_pc", tmp[63:0], 64'h2000 + 64'(4*i));
        end

        // Overflow with a stalled sink.
        log_data.delete(); log_last.delete();
        wr(8'h00, 64'h0);
        wr(8'h00, 64'h1); idle(1);
        tready = 0;
        for (int k = 0; k < 12; k++) ret(64'h3000 + 64'(4*k), 32'h13);
        tick();
        check("overflow_drop_count", drop_count, 4);
        check("overflow_no_beats", log_data.size(), 0);
        // Clear coinciding with a drop leaves one.
        ctrl_addr = 8'h03; ctrl_write_enable = 1; pc_valid = 1; pc = 64'h3100;
        tick(); tick();
        check("clear_with_drop", drop_count, 1);
        tready = 1;
        idle(12);
        check("overflow_retained", log_data.size(), 8);
        for (int i = 0; i < log_data.size(); i++) begin
            tmp = log_data[i];
            check("overflow_order", tmp[63:0], 64'h3000 + 64'(4*i));
        end
        wr(8'h03, 64'h0);
        check("drop_clear", drop_count, 0);

        // Reset with items buffered.
        tready = 0;
        for (int k = 0; k < 4; k++) ret(64'h4000 + 64'(4*k), 32'h13);
        tick();
        rst = 1;
        tick();
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_drop_count", drop_count, 0);
        rst = 0; tready = 1;
        log_data.delete(); log_last.delete();
        ret(64'h4100, 32'h13);
        idle(3);
        check("rst_idle_no_capture", log_data.size(), 0);

        // Packet boundaries.
        tlast_interval = 3;
        wr(8'h00, 64'h1); idle(1);
        for (int k = 0; k < 7; k++) ret(64'h5000 + 64'(4*k), 32'h13);
        idle(3);
        check("tlast3_beats", log_data.size(), 7);
        for (int i = 0; i < log_last.size(); i++)
            check("tlast3_flag", log_last[i], (i == 2) || (i == 5));
        log_data.delete(); log_last.delete();
        tlast_interval = 0;
        for (int k = 0; k < 4; k++) ret(64'h5100 + 64'(4*k), 32'h13);
        idle(3);
        check("tlast0_beats", log_data.size(), 4);
        for (int i = 0; i < log_last.size(); i++) check("tlast0_flag", log_last[i], 0);
        // Beat counter is 5 here: shrinking to 3 ends the packet on the next beat.
        log_data.delete(); log_last.delete();
        tlast_interval = 3;
        for (int k = 0; k < 4; k++) ret(64'h5200 + 64'(4*k), 32'h13);
        idle(3);
        check("tlast_shrink_beats", log_data.size(), 4);
        for (int i = 0; i < log_last.size(); i++)
            check("tlast_shrink_flag", log_last[i], (i == 0) || (i == 3));

        // Counter saturation.
        log_data.delete(); log_last.delete();
        for (int k = 0; k < 300; k++) begin
            performance_events = 37'h1;
            tick();
        end
        ret(64'h6000, 32'h33);
        idle(3);
        check("sat_beats", log_data.size(), 1);
        exp_item = (512'hFF << 96) | (512'h33 << 64) | 512'h6000;
        if (log_data.size() > 0) check("sat_item", log_data[0], exp_item);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cms_trace_packer.md
CMS_TRACE_PACKER -- requirements
Module: cms_trace_packer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 64, PC width.
- NO_OF_PERFORMANCE_EVENTS, 37, event input width.
- COUNTER_WIDTH, 8, per-event saturating counter width.
- CTRL_ADDR_WIDTH, 8, control address width.
- CTRL_DATA_WIDTH, 64, control data width.
- AXI_DATA_WIDTH, 512, stream beat width.
- FIFO_DEPTH, 8, output item buffer depth (power of two, >=2).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- rst, in, 1, synchronous active-high reset.
- instr, in, 32, retired instruction.
- pc, in, XLEN, retired PC.
- pc_valid, in, 1, instr/pc retire this cycle.
- performance_events, in, NO_OF_PERFORMANCE_EVENTS, one-cycle event pulses.
- ctrl_addr, in, CTRL_ADDR_WIDTH, control register address.
- ctrl_wdata, in, CTRL_DATA_WIDTH, control write data.
- ctrl_write_enable, in, 1, posedge-triggered write strobe.
- tlast_interval, in, 32, beats per packet; 0 = tlast never asserted.
- M_AXIS_tvalid, out, 1, beat valid.
- M_AXIS_tready, in, 1, sink ready.
- M_AXIS_tdata, out, AXI_DATA_WIDTH, beat payload.
- M_AXIS_tlast, out, 1, last beat of packet.
- drop_count, out, 32, items lost to full FIFO.
REQ-003 The design SHALL fail elaboration if XLEN+32+NO_OF_PERFORMANCE_EVENTS*COUNTER_WIDTH > AXI_DATA_WIDTH.

Function
REQ-004 A control write SHALL occur only on a cycle where ctrl_write_enable=1 and was 0 the previous cycle; the value is visible from the next cycle.
REQ-005 Register map: 0x00 bit0 MON_EN, bit1 TRIG_EN; 0x01 TRIG_START pc; 0x02 TRIG_STOP pc; 0x03 any write clears drop_count; other addresses ignored.
REQ-006 Trigger FSM states SHALL be IDLE, WAIT_START, ACTIVE.
REQ-007 IDLE->ACTIVE when MON_EN=1 and TRIG_EN=0; IDLE->WAIT_START when MON_EN=1 and TRIG_EN=1; any state->IDLE when MON_EN=0.
REQ-008 WAIT_START->ACTIVE when pc_valid and pc==TRIG_START; that item SHALL be captured.
REQ-009 ACTIVE->WAIT_START when TRIG_EN=1, pc_valid and pc==TRIG_STOP; that item SHALL be captured; START==STOP toggles on each match.
REQ-010 Each event SHALL have a COUNTER_WIDTH counter that increments by one per cycle its event bit is 1, saturating at all-ones, in every state.
REQ-011 Item capture (pc_valid in ACTIVE, or per REQ-008/009) SHALL form item = {zero pad, counters incl. this cycle's events, instr, pc}, pc in LSBs, event 0 counter lowest.
REQ-012 On capture with FIFO not full: push item, counters restart at this cycle's... zero next cycle (this cycle's events already included).
REQ-013 On capture with FIFO full: item dropped, counters NOT cleared, drop_count += 1 saturating at 2^32-1.
REQ-014 Simultaneous drop_count clear and drop SHALL yield drop_count = 1.
REQ-015 Capture-to-tvalid latency SHALL be 1 cycle when FIFO empty; simultaneous push and pop at full SHALL drop (full sampled before pop).
REQ-016 M_AXIS_tvalid SHALL equal FIFO non-empty; tdata/tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-017 A beat counter SHALL increment per handshake; tlast=1 when beat counter == tlast_interval-1, then counter wraps to 0.
REQ-018 tlast_interval change SHALL take effect on the next beat; if beat counter >= new interval-1, next beat SHALL assert tlast and wrap.
REQ-019 MON_EN=0 SHALL stop captures only; buffered items still drain.

Reset
REQ-020 On rst: FSM=IDLE, control registers 0, counters 0, FIFO empty, beat counter 0, drop_count 0, M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0; rst mid-packet discards buffered items.
REQ-021 The previous-write-enable register SHALL reset to 1 so a strobe held high through reset causes no write.

Structure
REQ-022 A shared package cms_pkg SHALL hold the FSM state enum, register address constants and default widths.
REQ-023 The item buffer SHALL be one sub-module, cms_sync_fifo (parametrised width/depth, full/empty flags).

Verification
REQ-024 MON_EN=1, TRIG_EN=0, tready=1, pc_valid at pc=0x1000 with event 3 pulsed twice before -> one beat, tdata[63:0]=0x1000, counter 3 = 2, others 0.
REQ-025 TRIG_EN=1, START=0x2000, STOP=0x2010, sweep pc 0x1FF8..0x2018 step 4 -> beats exactly for 0x2000..0x2010 (5 beats).
REQ-026 tready=0, 12 captures, FIFO_DEPTH=8 -> 8 beats retained in order, drop_count=4; write 0x03 -> drop_count=0.
REQ-027 tlast_interval=3, 7 beats -> tlast on beats 3 and 6 only; tlast_interval=0 -> no tlast.
REQ-028 Event 0 held high 300 cycles, no capture, then capture -> counter 0 = 0xFF.
REQ-029 rst asserted with 4 items buffered -> next cycle tvalid=0, drop_count=0, FSM IDLE.
